// File: rtl/free_list_pkg.sv
// Shared rename-stage definitions: sizes, PR type and a 4-bit popcount helper.
package free_list_pkg;

  localparam int NUM_PR = 64;
  localparam int NUM_AR = 32;
  localparam int PR_W   = 6;
  localparam int DEPTH  = NUM_PR - NUM_AR;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = IDX_W + 1;

  typedef logic [PR_W-1:0]  pr_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [IDX_W-1:0] idx_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/free_list_prefix_count4.sv
// Exclusive prefix counts and total of a 4-bit request vector; used to
// compact requests onto consecutive list positions.
module prefix_count4
  import free_list_pkg::*;
(
  input  logic [3:0]      vec_i,
  output logic [3:0][2:0] prefix_o,
  output logic [2:0]      total_o
);

  // Running count of set bits strictly below each slot.
  always_comb begin
    prefix_o[0] = 3'd0;
    for (int k = 1; k < 4; k++) begin
      prefix_o[k] = prefix_o[k-1] + 3'(vec_i[k-1]);
    end
    total_o = popcount4(vec_i);
  end

endmodule

// File: rtl/free_list.sv
// Circular physical-register free list with speculative head (rename side),
// committed head (retire side) and tail (release side).
// Optional sticky error checking is built when FREE_LIST_CHECK_EN is defined.
module free_list
  import free_list_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      flush_stage4,
  input  logic      inst0_alloc_req,
  input  logic      inst1_alloc_req,
  input  logic      inst2_alloc_req,
  input  logic      inst3_alloc_req,
  output logic      alloc_ready,
  output pr_t       inst0_alloc_PR,
  output pr_t       inst1_alloc_PR,
  output pr_t       inst2_alloc_PR,
  output pr_t       inst3_alloc_PR,
  input  logic      retire0_dest_en,
  input  logic      retire1_dest_en,
  input  logic      retire2_dest_en,
  input  logic      retire3_dest_en,
  input  logic      retire0_free_en,
  input  logic      retire1_free_en,
  input  logic      retire2_free_en,
  input  logic      retire3_free_en,
  input  pr_t       retire0_free_PR,
  input  pr_t       retire1_free_PR,
  input  pr_t       retire2_free_PR,
  input  pr_t       retire3_free_PR,
  output pr_t       free_count,
  output logic      fl_error
);

  pr_t  entries_q [DEPTH];
  ptr_t head_q, head_d;
  ptr_t a_head_q, a_head_d;
  ptr_t tail_q, tail_d;

  logic [3:0]      req, dest_en, free_en;
  pr_t             free_pr [4];
  pr_t             alloc_pr [4];
  logic [3:0][2:0] pre_alloc, pre_rel;
  logic [2:0]      n_alloc, n_rel, n_dest;

  assign req     = {inst3_alloc_req, inst2_alloc_req, inst1_alloc_req, inst0_alloc_req};
  assign dest_en = {retire3_dest_en, retire2_dest_en, retire1_dest_en, retire0_dest_en};
  assign free_en = {retire3_free_en, retire2_free_en, retire1_free_en, retire0_free_en};
  assign free_pr[0] = retire0_free_PR;
  assign free_pr[1] = retire1_free_PR;
  assign free_pr[2] = retire2_free_PR;
  assign free_pr[3] = retire3_free_PR;
  assign n_dest     = popcount4(dest_en);

  prefix_count4 u_alloc_cnt (.vec_i(req),     .prefix_o(pre_alloc), .total_o(n_alloc));
  prefix_count4 u_rel_cnt   (.vec_i(free_en), .prefix_o(pre_rel),   .total_o(n_rel));

  assign free_count  = tail_q - head_q;
  assign alloc_ready = free_count >= PR_W'(n_alloc);

  assign inst0_alloc_PR = alloc_pr[0];
  assign inst1_alloc_PR = alloc_pr[1];
  assign inst2_alloc_PR = alloc_pr[2];
  assign inst3_alloc_PR = alloc_pr[3];

  // Compacted combinational read starting at the speculative head.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      alloc_pr[k] = entries_q[head_q[IDX_W-1:0] + idx_t'(pre_alloc[k])];
    end
  end

  // Pointer next-state; a flush rewinds to the post-update committed head.
  always_comb begin
    a_head_d = a_head_q + ptr_t'(n_dest);
    tail_d   = tail_q + ptr_t'(n_rel);
    head_d   = head_q;
    if (flush_stage4) begin
      head_d = a_head_d;
    end else if (alloc_ready) begin
      head_d = head_q + ptr_t'(n_alloc);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      a_head_q <= '0;
      tail_q   <= ptr_t'(DEPTH);
    end else begin
      head_q   <= head_d;
      a_head_q <= a_head_d;
      tail_q   <= tail_d;
    end
  end

  // Entry array: reset to the unmapped PRs, released PRs written compacted at tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= pr_t'(NUM_AR + i);
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (free_en[k]) begin
          entries_q[tail_q[IDX_W-1:0] + idx_t'(pre_rel[k])] <= free_pr[k];
        end
      end
    end
  end

`ifdef FREE_LIST_CHECK_EN
  logic fl_error_q, err_now;

  // Overflow, release of PR 0, or duplicate PRs within one release group.
  always_comb begin
    err_now = ({1'b0, free_count} + 7'(n_rel)) > 7'(DEPTH);
    for (int k = 0; k < 4; k++) begin
      if (free_en[k] && (free_pr[k] == '0)) err_now = 1'b1;
      for (int j = k + 1; j < 4; j++) begin
        if (free_en[k] && free_en[j] && (free_pr[k] == free_pr[j])) err_now = 1'b1;
      end
    end
  end

  // Sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) fl_error_q <= 1'b0;
    else if (err_now) fl_error_q <= 1'b1;
  end

  assign fl_error = fl_error_q;
`else
  assign fl_error = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
module tb_free_list;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [3:0]      req_v, dest_v, fen_v;
  logic [3:0][5:0] fpr_v;
  logic            alloc_ready, fl_error;
  logic [5:0]      apr0, apr1, apr2, apr3, free_count;

  always #5 clk = ~clk;

  free_list dut (
    .clk(clk), .rst(rst), .flush_stage4(flush),
    .inst0_alloc_req(req_v[0]), .inst1_alloc_req(req_v[1]),
    .inst2_alloc_req(req_v[2]), .inst3_alloc_req(req_v[3]),
    .alloc_ready(alloc_ready),
    .inst0_alloc_PR(apr0), .inst1_alloc_PR(apr1),
    .inst2_alloc_PR(apr2), .inst3_alloc_PR(apr3),
    .retire0_dest_en(dest_v[0]), .retire1_dest_en(dest_v[1]),
    .retire2_dest_en(dest_v[2]), .retire3_dest_en(dest_v[3]),
    .retire0_free_en(fen_v[0]), .retire1_free_en(fen_v[1]),
    .retire2_free_en(fen_v[2]), .retire3_free_en(fen_v[3]),
    .retire0_free_PR(fpr_v[0]), .retire1_free_PR(fpr_v[1]),
    .retire2_free_PR(fpr_v[2]), .retire3_free_PR(fpr_v[3]),
    .free_count(free_count), .fl_error(fl_error)
  );

  typedef struct packed {
    logic            ready;
    logic [3:0]      mask;
    logic [3:0][5:0] pr;
    logic [5:0]      fc;
    logic            err;
    int              hand_fc;
    int              hand_ready;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Model: unbounded list of PRs in availability order with absolute positions.
  int mlist[$];
  int m_head, m_ahead, m_tail;
  logic m_err;
  logic [3:0][5:0] last_alloc;

  task automatic minit();
    mlist.delete();
    for (int i = 0; i < 32; i++) mlist.push_back(32 + i);
    m_head = 0; m_ahead = 0; m_tail = 32; m_err = 1'b0;
  endtask

  function automatic int pc4(input logic [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: each driven cycle presents one response, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [3:0][5:0] got;
      e = sb.pop_front();
      got = {apr3, apr2, apr1, apr0};
      chk("free_count", int'(free_count), int'(e.fc));
      chk("alloc_ready", int'(alloc_ready), int'(e.ready));
      chk("fl_error", int'(fl_error), int'(e.err));
      if (e.hand_fc >= 0) chk("free_count_hand", int'(free_count), e.hand_fc);
      if (e.hand_ready >= 0) chk("alloc_ready_hand", int'(alloc_ready), e.hand_ready);
      if (e.ready) begin
        for (int k = 0; k < 4; k++) begin
          if (e.mask[k]) chk($sformatf("alloc_PR%0d", k), int'(got[k]), int'(e.pr[k]));
        end
      end
    end
  end

  task automatic cyc(input logic [3:0] req, input logic [3:0] dest, input logic [3:0] fen,
                     input logic [3:0][5:0] fpr, input logic fl, input int hfc, input int hrdy);
    exp_t e;
    int n, nrel, fc, p;
    req_v = req; dest_v = dest; fen_v = fen; fpr_v = fpr; flush = fl;
    n = pc4(req); nrel = pc4(fen);
    fc = m_tail - m_head;
    e = '0;
    e.ready = (fc >= n);
    e.mask = req;
    e.fc = 6'(fc);
    e.err = m_err;
    e.hand_fc = hfc;
    e.hand_ready = hrdy;
    p = 0;
    for (int k = 0; k < 4; k++) begin
      if (req[k]) begin
        if (e.ready) e.pr[k] = 6'(mlist[m_head + p]);
        p++;
      end
    end
    last_alloc = e.pr;
    sb.push_back(e);
`ifdef FREE_LIST_CHECK_EN
    if (fc + nrel > 32) m_err = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (fen[k] && fpr[k] == 6'd0) m_err = 1'b1;
      for (int j = k + 1; j < 4; j++)
        if (fen[k] && fen[j] && fpr[k] == fpr[j]) m_err = 1'b1;
    end
`endif
    m_ahead += pc4(dest);
    if (fl) m_head = m_ahead;
    else if (e.ready) m_head += n;
    for (int k = 0; k < 4; k++) begin
      if (fen[k]) begin
        if (m_tail < mlist.size()) mlist[m_tail] = int'(fpr[k]);
        else mlist.push_back(int'(fpr[k]));
        m_tail++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_v = '0; dest_v = '0; fen_v = '0; fpr_v = '0; flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    minit();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][5:0] rel;
    do_reset();
    // Full-width allocation from reset state.
    cyc(4'b1111, '0, '0, '0, 1'b0, 32, 1);
    cyc(4'b0000, '0, '0, '0, 1'b0, 28, 1);

    // Sparse request compaction, then drain to 2 and stall a 3-wide request.
    do_reset();
    cyc(4'b1010, '0, '0, '0, 1'b0, 32, 1);
    cyc(4'b0000, '0, '0, '0, 1'b0, 30, 1);
    repeat (7) cyc(4'b1111, '0, '0, '0, 1'b0, -1, -1);
    rel = '0; rel[0] = 6'd10;
    cyc(4'b0111, '0, 4'b0001, rel, 1'b0, 2, 0);
    cyc(4'b0111, '0, '0, '0, 1'b0, 3, 1);
    cyc(4'b0001, '0, '0, '0, 1'b0, 0, 0);

    // Flush back to committed head with same-cycle alloc discarded.
    do_reset();
    cyc(4'b1111, 4'b0011, '0, '0, 1'b0, 32, 1);
    cyc(4'b1111, 4'b0011, '0, '0, 1'b0, 28, 1);
    cyc(4'b1111, 4'b0001, '0, '0, 1'b1, 24, 1);
    cyc(4'b0001, '0, '0, '0, 1'b0, 27, 1);
    cyc(4'b0000, '0, '0, '0, 1'b0, 26, 1);

    // Alternate alloc 4 / release those 4; pointers wrap.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        cyc(4'b1111, '0, '0, '0, 1'b0, 32, 1);
        rel = last_alloc;
      end else begin
        cyc(4'b0000, '0, 4'b1111, rel, 1'b0, 28, 1);
      end
    end

    // Release into a full list.
    rel = '0; rel[0] = 6'd40;
    cyc(4'b0000, '0, 4'b0001, rel, 1'b0, 32, 1);
    cyc(4'b0000, '0, '0, '0, 1'b0, -1, -1);
    cyc(4'b0000, '0, '0, '0, 1'b0, -1, -1);
    do_reset();
    cyc(4'b0000, '0, '0, '0, 1'b0, 32, 1);

    for (int t = 0; t < 10 && sb.size() > 0; t++) @(posedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
